// File: rtl/memory_bus_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and memory_bus.
// slave is the arbiter side, master is the requester/memory side.
interface memory_bus_arbiter_if;
    logic        m0_req;
    logic [23:0] m0_address;
    logic [7:0]  m0_data_in;
    logic        m0_write_enable;
    logic        m0_ack;
    logic [7:0]  m0_data_out;
    logic        m0_error;

    logic        m1_req;
    logic [23:0] m1_address;
    logic [7:0]  m1_data_in;
    logic        m1_write_enable;
    logic        m1_ack;
    logic [7:0]  m1_data_out;
    logic        m1_error;

    logic [23:0] bus_address;
    logic [7:0]  bus_data_in;
    logic [7:0]  bus_data_out;
    logic        bus_enable;
    logic        bus_write_enable;
    logic        bus_halt;
    logic        busy;

    modport slave (
        input  m0_req, m0_address, m0_data_in, m0_write_enable,
        output m0_ack, m0_data_out, m0_error,
        input  m1_req, m1_address, m1_data_in, m1_write_enable,
        output m1_ack, m1_data_out, m1_error,
        output bus_address, bus_data_in, bus_enable, bus_write_enable,
        input  bus_data_out, bus_halt,
        output busy
    );

    modport master (
        output m0_req, m0_address, m0_data_in, m0_write_enable,
        input  m0_ack, m0_data_out, m0_error,
        output m1_req, m1_address, m1_data_in, m1_write_enable,
        input  m1_ack, m1_data_out, m1_error,
        input  bus_address, bus_data_in, bus_enable, bus_write_enable,
        output bus_data_out, bus_halt,
        input  busy
    );
endinterface

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter sharing memory_bus between CPU (m0) and DMA (m1).
// One transaction per grant; a halt timeout frees the bus from a hung SD card.
module memory_bus_arbiter #(
    parameter int unsigned ACCESS_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input logic                 clk,
    input logic                 reset,
    memory_bus_arbiter_if.slave bif
);
    localparam int unsigned HW =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [3:0]    ACC_LAST   = 4'(ACCESS_CYCLES - 1);
    localparam logic [HW-1:0] HALT_LAST  = HW'(TIMEOUT_CYCLES - 1);
    localparam logic [HW-1:0] HALT_MAX   = '1;
    localparam bit            TIMEOUT_ON = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          owner;
    logic          last_grant;
    logic          we_q;
    logic [23:0]   addr_q;
    logic [7:0]    din_q;
    logic [3:0]    access_cnt;
    logic [HW-1:0] halt_cnt;
    logic [7:0]    q0;
    logic [7:0]    q1;
    logic          e0;
    logic          e1;

    logic          any_req;
    logic          grant_sel;
    logic          finish;
    logic          expire;

    // Arbitration choice and end-of-access conditions.
    always_comb begin
        any_req   = bif.m0_req | bif.m1_req;
        grant_sel = (bif.m0_req & bif.m1_req) ? ~last_grant : bif.m1_req;
        finish    = (state == ACCESS) && !bif.bus_halt
                    && (access_cnt == ACC_LAST);
        expire    = TIMEOUT_ON && (state == ACCESS) && bif.bus_halt
                    && (halt_cnt == HALT_LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (any_req) state_next = ACCESS;
            ACCESS:  if (finish || expire) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grant latch: owner, bus fields and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
        end else if (state == IDLE && any_req) begin
            owner      <= grant_sel;
            last_grant <= grant_sel;
            if (grant_sel) begin
                we_q   <= bif.m1_write_enable;
                addr_q <= bif.m1_address;
                din_q  <= bif.m1_data_in;
            end else begin
                we_q   <= bif.m0_write_enable;
                addr_q <= bif.m0_address;
                din_q  <= bif.m0_data_in;
            end
        end
    end

    // Access and halt counters; halt count saturates instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            access_cnt <= '0;
            halt_cnt   <= '0;
        end else if (state == IDLE) begin
            access_cnt <= '0;
            halt_cnt   <= '0;
        end else if (state == ACCESS) begin
            if (bif.bus_halt) begin
                if (halt_cnt != HALT_MAX) halt_cnt <= halt_cnt + 1'b1;
            end else begin
                halt_cnt   <= '0;
                access_cnt <= access_cnt + 1'b1;
            end
        end
    end

    // Per-master result registers; only the owner's copy changes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q0 <= 8'h00;
            q1 <= 8'h00;
            e0 <= 1'b0;
            e1 <= 1'b0;
        end else if (expire) begin
            if (owner) begin
                q1 <= 8'hFF;
                e1 <= 1'b1;
            end else begin
                q0 <= 8'hFF;
                e0 <= 1'b1;
            end
        end else if (finish) begin
            if (owner) begin
                if (!we_q) q1 <= bif.bus_data_out;
                e1 <= 1'b0;
            end else begin
                if (!we_q) q0 <= bif.bus_data_out;
                e0 <= 1'b0;
            end
        end
    end

    // Bus strobes decode straight from state so reset drops them at once.
    assign bif.bus_enable       = (state == ACCESS);
    assign bif.bus_write_enable = (state == ACCESS) && we_q;
    assign bif.bus_address      = addr_q;
    assign bif.bus_data_in      = din_q;
    assign bif.busy             = (state != IDLE);

    assign bif.m0_ack      = (state == DONE) && !owner;
    assign bif.m1_ack      = (state == DONE) && owner;
    assign bif.m0_data_out = q0;
    assign bif.m1_data_out = q1;
    assign bif.m0_error    = e0;
    assign bif.m1_error    = e1;
endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter: cycle table plus
// hand sequences for halt, timeout and mid-access reset.
module tb_memory_bus_arbiter;
    logic clk;
    logic reset;

    memory_bus_arbiter_if bif ();

    memory_bus_arbiter #(
        .ACCESS_CYCLES (2),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bif  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  ctl;
        logic [23:0] a0;
        logic [7:0]  d0;
        logic [23:0] a1;
        logic [7:0]  d1;
        logic [7:0]  bdo;
        logic [6:0]  flg;
        logic [23:0] baddr;
        logic [7:0]  bdin;
        logic [7:0]  q0;
        logic [7:0]  q1;
    } vec_t;

    vec_t tbl[$];
    int   errors;
    int   checks;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input bit m, input logic v);
        if (m) bif.m1_req = v;
        else   bif.m0_req = v;
    endtask

    task automatic run_txn(input bit m, input int halts,
                           input logic [23:0] exp_addr,
                           output int ack_at, output int en_cnt,
                           output int bad);
        ack_at = 0;
        en_cnt = 0;
        bad    = 0;
        @(negedge clk);
        set_req(m, 1'b1);
        @(posedge clk);
        #1;
        for (int k = 1; k <= 40; k++) begin
            if (bif.bus_enable) begin
                en_cnt++;
                if (bif.bus_address !== exp_addr) bad++;
            end
            if (m ? bif.m0_ack : bif.m1_ack) bad++;
            if (m ? bif.m1_ack : bif.m0_ack) begin
                ack_at = k;
                break;
            end
            bif.bus_halt = (k <= halts);
            @(posedge clk);
            #1;
        end
        bif.bus_halt = 1'b0;
        set_req(m, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int ack_at;
        int en_cnt;
        int bad;
        int a1_cnt;
        errors = 0;
        checks = 0;

        // ctl = {r0, we0, r1, we1, halt}
        // flg = {busy, en, bwe, ack0, err0, ack1, err1}
        tbl.push_back('{5'b10000, 24'h000010, 8'h00, 24'h000000, 8'h00, 8'h5A, 7'b1100000, 24'h000010, 8'h00, 8'h00, 8'h00});
        tbl.push_back('{5'b10000, 24'h000010, 8'h00, 24'h000000, 8'h00, 8'h5A, 7'b1100000, 24'h000010, 8'h00, 8'h00, 8'h00});
        tbl.push_back('{5'b10000, 24'h000010, 8'h00, 24'h000000, 8'h00, 8'h5A, 7'b1001000, 24'h000010, 8'h00, 8'h5A, 8'h00});
        tbl.push_back('{5'b00000, 24'h000010, 8'h00, 24'h000000, 8'h00, 8'h5A, 7'b0000000, 24'h000010, 8'h00, 8'h5A, 8'h00});
        tbl.push_back('{5'b00110, 24'h000000, 8'h00, 24'h008004, 8'h3C, 8'h77, 7'b1110000, 24'h008004, 8'h3C, 8'h5A, 8'h00});
        tbl.push_back('{5'b00110, 24'h000000, 8'h00, 24'h111111, 8'hEE, 8'h77, 7'b1110000, 24'h008004, 8'h3C, 8'h5A, 8'h00});
        tbl.push_back('{5'b00110, 24'h000000, 8'h00, 24'h111111, 8'hEE, 8'h77, 7'b1000010, 24'h008004, 8'h3C, 8'h5A, 8'h00});
        tbl.push_back('{5'b00000, 24'h000000, 8'h00, 24'h000000, 8'h00, 8'h77, 7'b0000000, 24'h008004, 8'h3C, 8'h5A, 8'h00});
        tbl.push_back('{5'b10100, 24'h000100, 8'h00, 24'h000200, 8'h00, 8'h11, 7'b1100000, 24'h000100, 8'h00, 8'h5A, 8'h00});
        tbl.push_back('{5'b10100, 24'h000100, 8'h00, 24'h000200, 8'h00, 8'h11, 7'b1100000, 24'h000100, 8'h00, 8'h5A, 8'h00});
        tbl.push_back('{5'b10100, 24'h000100, 8'h00, 24'h000200, 8'h00, 8'h11, 7'b1001000, 24'h000100, 8'h00, 8'h11, 8'h00});
        tbl.push_back('{5'b10100, 24'h000100, 8'h00, 24'h000200, 8'h00, 8'h22, 7'b0000000, 24'h000100, 8'h00, 8'h11, 8'h00});
        tbl.push_back('{5'b10100, 24'h000100, 8'h00, 24'h000200, 8'h00, 8'h22, 7'b1100000, 24'h000200, 8'h00, 8'h11, 8'h00});
        tbl.push_back('{5'b10100, 24'h000100, 8'h00, 24'h000200, 8'h00, 8'h22, 7'b1100000, 24'h000200, 8'h00, 8'h11, 8'h00});
        tbl.push_back('{5'b10100, 24'h000100, 8'h00, 24'h000200, 8'h00, 8'h22, 7'b1000010, 24'h000200, 8'h00, 8'h11, 8'h22});
        tbl.push_back('{5'b10100, 24'h000100, 8'h00, 24'h000200, 8'h00, 8'h33, 7'b0000000, 24'h000200, 8'h00, 8'h11, 8'h22});
        tbl.push_back('{5'b10100, 24'h000100, 8'h00, 24'h000200, 8'h00, 8'h33, 7'b1100000, 24'h000100, 8'h00, 8'h11, 8'h22});
        tbl.push_back('{5'b10100, 24'h000100, 8'h00, 24'h000200, 8'h00, 8'h33, 7'b1100000, 24'h000100, 8'h00, 8'h11, 8'h22});
        tbl.push_back('{5'b10100, 24'h000100, 8'h00, 24'h000200, 8'h00, 8'h33, 7'b1001000, 24'h000100, 8'h00, 8'h33, 8'h22});
        tbl.push_back('{5'b10100, 24'h000100, 8'h00, 24'h000200, 8'h00, 8'h44, 7'b0000000, 24'h000100, 8'h00, 8'h33, 8'h22});
        tbl.push_back('{5'b10100, 24'h000100, 8'h00, 24'h000200, 8'h00, 8'h44, 7'b1100000, 24'h000200, 8'h00, 8'h33, 8'h22});
        tbl.push_back('{5'b10100, 24'h000100, 8'h00, 24'h000200, 8'h00, 8'h44, 7'b1100000, 24'h000200, 8'h00, 8'h33, 8'h22});
        tbl.push_back('{5'b10100, 24'h000100, 8'h00, 24'h000200, 8'h00, 8'h44, 7'b1000010, 24'h000200, 8'h00, 8'h33, 8'h44});
        tbl.push_back('{5'b00000, 24'h000100, 8'h00, 24'h000200, 8'h00, 8'h44, 7'b0000000, 24'h000200, 8'h00, 8'h33, 8'h44});

        reset               = 1'b0;
        bif.m0_req          = 1'b0;
        bif.m0_address      = '0;
        bif.m0_data_in      = '0;
        bif.m0_write_enable = 1'b0;
        bif.m1_req          = 1'b0;
        bif.m1_address      = '0;
        bif.m1_data_in      = '0;
        bif.m1_write_enable = 1'b0;
        bif.bus_data_out    = '0;
        bif.bus_halt        = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 32'(bif.busy), 0);
        chk("reset en", 32'(bif.bus_enable), 0);
        chk("reset bwe", 32'(bif.bus_write_enable), 0);
        chk("reset addr", 32'(bif.bus_address), 0);
        chk("reset bdin", 32'(bif.bus_data_in), 0);
        chk("reset acks", 32'({bif.m0_ack, bif.m1_ack}), 0);
        chk("reset errs", 32'({bif.m0_error, bif.m1_error}), 0);
        chk("reset q0", 32'(bif.m0_data_out), 0);
        chk("reset q1", 32'(bif.m1_data_out), 0);

        @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) begin
            bif.m0_req          = tbl[i].ctl[4];
            bif.m0_write_enable = tbl[i].ctl[3];
            bif.m1_req          = tbl[i].ctl[2];
            bif.m1_write_enable = tbl[i].ctl[1];
            bif.bus_halt        = tbl[i].ctl[0];
            bif.m0_address      = tbl[i].a0;
            bif.m0_data_in      = tbl[i].d0;
            bif.m1_address      = tbl[i].a1;
            bif.m1_data_in      = tbl[i].d1;
            bif.bus_data_out    = tbl[i].bdo;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d flags", i),
                32'({bif.busy, bif.bus_enable, bif.bus_write_enable,
                     bif.m0_ack, bif.m0_error, bif.m1_ack, bif.m1_error}),
                32'(tbl[i].flg));
            chk($sformatf("v%0d addr", i), 32'(bif.bus_address),
                32'(tbl[i].baddr));
            chk($sformatf("v%0d bdin", i), 32'(bif.bus_data_in),
                32'(tbl[i].bdin));
            chk($sformatf("v%0d q0", i), 32'(bif.m0_data_out),
                32'(tbl[i].q0));
            chk($sformatf("v%0d q1", i), 32'(bif.m1_data_out),
                32'(tbl[i].q1));
            @(negedge clk);
        end

        bif.m0_address      = 24'hC00000;
        bif.m0_write_enable = 1'b0;
        bif.bus_data_out    = 8'h9C;
        run_txn(1'b0, 5, 24'hC00000, ack_at, en_cnt, bad);
        chk("halt ack cycle", 32'(ack_at), 8);
        chk("halt en cycles", 32'(en_cnt), 7);
        chk("halt bad", 32'(bad), 0);
        chk("halt q0", 32'(bif.m0_data_out), 32'h9C);
        chk("halt err0", 32'(bif.m0_error), 0);
        chk("halt q1 held", 32'(bif.m1_data_out), 32'h44);

        bif.m1_address      = 24'h123456;
        bif.m1_write_enable = 1'b0;
        bif.bus_data_out    = 8'h12;
        run_txn(1'b1, 100, 24'h123456, ack_at, en_cnt, bad);
        chk("tmo ack cycle", 32'(ack_at), 9);
        chk("tmo en cycles", 32'(en_cnt), 8);
        chk("tmo bad", 32'(bad), 0);
        chk("tmo q1", 32'(bif.m1_data_out), 32'hFF);
        chk("tmo err1", 32'(bif.m1_error), 1);

        bif.m0_address   = 24'h000777;
        bif.bus_data_out = 8'h6E;
        run_txn(1'b0, 0, 24'h000777, ack_at, en_cnt, bad);
        chk("post ack cycle", 32'(ack_at), 3);
        chk("post en cycles", 32'(en_cnt), 2);
        chk("post bad", 32'(bad), 0);
        chk("post q0", 32'(bif.m0_data_out), 32'h6E);
        chk("post err0", 32'(bif.m0_error), 0);
        chk("post err1 held", 32'(bif.m1_error), 1);

        @(negedge clk);
        bif.m1_req     = 1'b1;
        bif.m1_address = 24'h0ABCDE;
        @(posedge clk);
        #1;
        chk("rst pre en", 32'(bif.bus_enable), 1);
        #1;
        reset = 1'b0;
        #1;
        chk("rst en drop", 32'(bif.bus_enable), 0);
        chk("rst busy drop", 32'(bif.busy), 0);
        chk("rst ack1", 32'(bif.m1_ack), 0);
        bif.m0_req       = 1'b1;
        bif.m0_address   = 24'h00BEEF;
        bif.bus_data_out = 8'hA5;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst hold ack1", 32'(bif.m1_ack), 0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst tie en", 32'(bif.bus_enable), 1);
        chk("rst tie addr", 32'(bif.bus_address), 32'h00BEEF);
        ack_at = 0;
        a1_cnt = 0;
        for (int k = 2; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (bif.m0_ack && ack_at == 0) ack_at = k;
            if (bif.m1_ack) a1_cnt++;
        end
        bif.m0_req = 1'b0;
        bif.m1_req = 1'b0;
        chk("rst m0 ack cycle", 32'(ack_at), 3);
        chk("rst no ack1", 32'(a1_cnt), 0);
        chk("rst q0", 32'(bif.m0_data_out), 32'hA5);
        chk("rst q1 cleared", 32'(bif.m1_data_out), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("end idle", 32'(bif.busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
